// File: rtl/base_acredit_snk.sv
// base_acredit_snk -- receive side of a credit-based link.
//
// Beats arrive on i_v/i_d with no back-pressure. The transmitter holds
// 'depth' credits after reset and spends one per beat. Accepted beats are
// buffered in a circular FIFO and presented downstream on registered
// o_v/o_d. One i_crd pulse is returned the cycle after each pop.
//
// Handshake: downstream transfer happens on a rising edge where
// o_v=1 and o_r=1 (pop). o_d is held stable while o_v=1 and o_r=0. A beat
// arriving while the FIFO is full and no pop is happening is discarded,
// and no credit is ever returned for it.
//
// Optional feature: define BASE_ACREDIT_SNK_OVF_CHECK_EN to make o_err a
// sticky overflow flag. Without it o_err is tied to 0 and the detection
// logic is absent. Discard behaviour is the same in both builds.
//
// Data vectors are declared [0:N-1] so that bit 0 is the MSB.

module base_acredit_snk #(
    parameter int width     = 1,
    parameter int del_width = 0,
    parameter int depth     = 4
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          i_v,
    input  logic [0:width+del_width-1]    i_d,
    output logic                          i_crd,
    output logic                          o_v,
    output logic [0:width+del_width-1]    o_d,
    input  logic                          o_r,
    output logic                          o_err
);

    localparam int DW = width + del_width;
    localparam int AW = $clog2(depth);
    localparam int CW = AW + 1;

    // Storage and bookkeeping state
    logic [0:DW-1]   r_mem [depth];
    logic [AW-1:0]   r_rd;
    logic [AW-1:0]   r_wr;
    logic [CW-1:0]   r_cnt;
    logic            r_ov;
    logic [0:DW-1]   r_od;
    logic            r_crd;

    // Per-cycle decisions
    logic            w_pop;
    logic            w_full;
    logic            w_push;
    logic [AW-1:0]   w_rd_nxt;
    logic [AW-1:0]   w_wr_nxt;
    logic [CW-1:0]   w_cnt_nxt;
    logic [0:DW-1]   w_head_nxt;

    assign w_pop  = r_ov & o_r;
    assign w_full = (r_cnt == CW'(depth));
    // A full FIFO can still take a beat when the head leaves in the same cycle.
    assign w_push = i_v & (~w_full | w_pop);

    // Next pointers, occupancy and the entry that will be at the head
    always_comb begin
        w_rd_nxt   = r_rd;
        w_wr_nxt   = r_wr;
        w_cnt_nxt  = r_cnt;
        w_head_nxt = r_mem[r_rd];
        if (w_pop) begin
            w_rd_nxt = r_rd + AW'(1);
        end
        if (w_push) begin
            w_wr_nxt = r_wr + AW'(1);
        end
        case ({w_push, w_pop})
            2'b10:   w_cnt_nxt = r_cnt + CW'(1);
            2'b01:   w_cnt_nxt = r_cnt - CW'(1);
            default: w_cnt_nxt = r_cnt;
        endcase
        // The write slot can only coincide with the new head when the
        // queue (after this cycle's pop) would otherwise be empty, so in
        // that case the incoming beat bypasses straight to the output.
        if (w_push && (r_wr == w_rd_nxt)) begin
            w_head_nxt = i_d;
        end else begin
            w_head_nxt = r_mem[w_rd_nxt];
        end
    end

    // Buffer write; no reset needed since occupancy gates every read
    always_ff @(posedge clk) begin
        if (reset && w_push) begin
            r_mem[r_wr] <= i_d;
        end
    end

    // Pointers, count, registered head, and credit pulse
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_rd  <= '0;
            r_wr  <= '0;
            r_cnt <= '0;
            r_ov  <= 1'b0;
            r_od  <= '0;
            r_crd <= 1'b0;
        end else begin
            r_rd  <= w_rd_nxt;
            r_wr  <= w_wr_nxt;
            r_cnt <= w_cnt_nxt;
            r_ov  <= (w_cnt_nxt != '0);
            // Hold the last value when going empty to avoid needless toggling.
            if (w_cnt_nxt != '0) begin
                r_od <= w_head_nxt;
            end
            r_crd <= w_pop;
        end
    end

    assign o_v   = r_ov;
    assign o_d   = r_od;
    assign i_crd = r_crd;

`ifdef BASE_ACREDIT_SNK_OVF_CHECK_EN
    logic w_ovf;
    logic r_err;

    assign w_ovf = i_v & w_full & ~w_pop;

    // Sticky overflow flag, cleared only by reset
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_err <= 1'b0;
        end else if (w_ovf) begin
            r_err <= 1'b1;
        end
    end

    assign o_err = r_err;
`else
    assign o_err = 1'b0;
`endif

endmodule

// File: doc/base_acredit_snk.md
BASE_ACREDIT_SNK -- requirements
Module: base_acredit_snk

Interface
REQ-001 SHALL have parameter width, default 1, payload bits per beat.
REQ-002 SHALL have parameter del_width, default 0, extra sideband bits carried unmodified with payload.
REQ-003 SHALL have parameter depth, default 4, buffer entries; legal values are powers of two, 2..16.
REQ-004 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-low reset.
REQ-006 SHALL have port i_v  input  1  beat valid from credit-based transmitter; no ready returned.
REQ-007 SHALL have port i_d  input  width+del_width  beat data, bit 0 is MSB.
REQ-008 SHALL have port i_crd  output  1  credit return, one-cycle pulse per freed entry.
REQ-009 SHALL have port o_v  output  1  head entry valid to downstream.
REQ-010 SHALL have port o_d  output  width+del_width  head entry data.
REQ-011 SHALL have port o_r  input  1  downstream ready.
REQ-012 SHALL have port o_err  output  1  sticky overflow flag.

Function
REQ-013 SHALL store beats in a depth-entry circular FIFO with read pointer, write pointer and occupancy count of clog2(depth)+1 bits.
REQ-014 SHALL define push = i_v on any cycle; pop = o_v & o_r.
REQ-015 SHALL accept a push when count < depth, or when count == depth and pop is asserted in the same cycle.
REQ-016 SHALL treat a push with count == depth and no pop as overflow: beat discarded, pointers and count unchanged.
REQ-017 SHALL drive o_v and o_d from registers; a beat pushed into an empty FIFO at cycle N SHALL appear on o_v/o_d at cycle N+1.
REQ-018 SHALL hold o_d stable while o_v=1 and o_r=0.
REQ-019 SHALL advance to the next entry in the cycle after a pop, so back-to-back pops sustain one beat per cycle.
REQ-020 SHALL update count as +1 on push only, -1 on pop only, and unchanged on simultaneous push and pop.
REQ-021 SHALL wrap both pointers modulo depth with no bubble at the wrap boundary.
REQ-022 SHALL assert i_crd for exactly one cycle, the cycle after each pop; N pops SHALL yield N credit pulses.
REQ-023 SHALL NOT return credits for beats discarded on overflow.
REQ-024 SHALL imply depth initial credits held by the transmitter after reset; no credit pulses are issued at reset exit.

Reset
REQ-025 SHALL, while reset=0 at a clock edge, clear pointers, count, o_v, i_crd and o_err to 0.
REQ-026 SHALL drive o_d to 0 at reset.
REQ-027 SHALL discard all stored beats on reset mid-operation and issue no credit pulses for them.
REQ-028 SHALL ignore i_v and o_r on any cycle where reset=0.

Configuration
REQ-029 SHALL recognise macro BASE_ACREDIT_SNK_OVF_CHECK_EN.
REQ-030 SHALL, with the macro defined, set o_err on the first overflow and hold it until reset.
REQ-031 SHALL, without the macro, tie o_err to 0 and omit the detection logic; overflow discard behaviour is unchanged.

Verification
REQ-032 SHALL cover: reset, then single i_v with i_d=0x1 and o_r=1 -> o_v=1 with o_d=0x1 at the next cycle, then i_crd pulse one cycle after the pop.
REQ-033 SHALL cover: depth=4, o_r=0, four pushes 0xA..0xD, then o_r=1 -> outputs A,B,C,D on four consecutive cycles and four i_crd pulses.
REQ-034 SHALL cover: depth=4 full, a fifth i_v with o_r=1 in the same cycle -> beat accepted, count stays 4, o_err=0.
REQ-035 SHALL cover: depth=4 full, o_r=0, a fifth i_v=0xE -> 0xE never appears on o_d, no credit returned for it, o_err=1 with macro and 0 without.
REQ-036 SHALL cover: 3 entries stored, reset=0 for one cycle -> o_v=0, count=0, no i_crd pulses, o_err=0.
REQ-037 SHALL cover: continuous push and pop for 3*depth beats with incrementing data -> in-order delivery across pointer wrap, no bubbles, count constant.
